// File: rtl/pu_mux_bank.sv
// ---------------------------------------------------------------------------
// pu_mux_bank
//
// Lane crossbar plus per-lane accumulator bank that sits in front of the
// processing-unit register file. One transfer carries LANES operand bytes.
// Every output lane selects any input lane. Depending on the transfer mode,
// the lane then does one of three things:
//   - passes the routed value through,
//   - loads the routed value into its accumulator, or
//   - adds the routed value into its accumulator, saturating at all-ones.
// Results are queued in a DEPTH-entry FIFO. Consumer back-pressure throttles
// the producer through in_ready.
//
// Pipeline:
//   accept edge -> S1 register (operands, selects, mode)
//   next edge   -> routed/accumulated result written to FIFO tail
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   producer offers a transfer
//   in_ready   block can take a transfer (space reserved for S1 + FIFO)
//   vrd_i      LANES operands, lane k at [k*DW +: DW]
//   sel_i      per-output-lane source select, lane k at [k*SW +: SW]
//   mode_i     0/1 pass, 2 accumulate (saturating), 3 load
//   out_valid  FIFO head valid
//   out_ready  consumer takes the head
//   vrd_o      FIFO head data (zero when the FIFO is empty)
//   sat_o      sticky per-lane saturation flags
//   level_o    FIFO occupancy
// ---------------------------------------------------------------------------
module pu_mux_bank #(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int SW    = $clog2(LANES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*DW-1:0]        vrd_i,
  input  logic [LANES*SW-1:0]        sel_i,
  input  logic [1:0]                 mode_i,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*DW-1:0]        vrd_o,
  output logic [LANES-1:0]           sat_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] MODE_ACC  = 2'd2;
  localparam logic [1:0] MODE_LOAD = 2'd3;

  // Unsigned add with clamp to all-ones.
  // The MSB of the return value flags that the clamp was applied.
  function automatic logic [DW:0] sat_add(input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [DW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[DW]) begin
      sat_add = {1'b1, {DW{1'b1}}};
    end else begin
      sat_add = sum;
    end
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic                  s1_valid_q, s1_valid_d;
  logic [LANES*DW-1:0]   s1_vrd_q;
  logic [LANES*SW-1:0]   s1_sel_q;
  logic [1:0]            s1_mode_q;

  logic [DW-1:0]         acc_q [LANES];
  logic [DW-1:0]         acc_d [LANES];
  logic [LANES-1:0]      sat_q, sat_d;

  logic [LANES*DW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic accept;
  logic push;
  logic pop;

  // The S1 entry already counts against FIFO space.
  // This means its push on the following edge can never overflow the FIFO.
  // A pop in the current cycle is deliberately not credited here.
  // That keeps in_ready a function of registered state only.
  assign in_ready  = !rst &&
                     (({1'b0, level_q} + {{LW{1'b0}}, s1_valid_q}) <
                      {1'b0, LW'(DEPTH)});
  assign out_valid = (level_q != '0);

  assign accept = in_valid && in_ready;
  assign push   = s1_valid_q;
  assign pop    = out_valid && out_ready;

  // -------------------------------------------------------------------------
  // S1 compute: crossbar, then per-lane pass / load / accumulate
  // -------------------------------------------------------------------------
  logic [DW-1:0]       in_lane [LANES];
  logic [DW-1:0]       route   [LANES];
  logic [DW:0]         add_w   [LANES];
  logic [LANES*DW-1:0] push_data;

  always_comb begin
    push_data = '0;
    sat_d     = sat_q;
    for (int k = 0; k < LANES; k++) begin
      in_lane[k] = s1_vrd_q[k*DW +: DW];
    end
    for (int k = 0; k < LANES; k++) begin
      route[k] = in_lane[s1_sel_q[k*SW +: SW]];
      add_w[k] = sat_add(acc_q[k], route[k]);
      acc_d[k] = acc_q[k];
      push_data[k*DW +: DW] = route[k];
      if (s1_valid_q) begin
        case (s1_mode_q)
          MODE_ACC: begin
            acc_d[k]              = add_w[k][DW-1:0];
            push_data[k*DW +: DW] = add_w[k][DW-1:0];
            if (add_w[k][DW]) begin
              sat_d[k] = 1'b1;
            end
          end
          MODE_LOAD: begin
            acc_d[k] = route[k];
            sat_d[k] = 1'b0;
          end
          default: begin
            // pass modes leave the accumulator and sat flag untouched
          end
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d    = level_q;
    s1_valid_d = accept;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control registers (reset)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      sat_q      <= '0;
      for (int k = 0; k < LANES; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      sat_q      <= sat_d;
      for (int k = 0; k < LANES; k++) begin
        acc_q[k] <= acc_d[k];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Data registers (no reset; qualified by the valid/level state above)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_vrd_q  <= vrd_i;
      s1_sel_q  <= sel_i;
      s1_mode_q <= mode_i;
    end
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Gate the head with out_valid.
  // This keeps vrd_o at zero after reset, even though the storage itself is
  // never cleared.
  assign vrd_o   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign sat_o   = sat_q;
  assign level_o = level_q;

endmodule

// File: tb/tb_pu_mux_bank.sv
module tb_pu_mux_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] vrd_i;
  logic [7:0]  sel_i;
  logic [1:0]  mode_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] vrd_o;
  logic [3:0]  sat_o;
  logic [3:0]  level_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]  acc_m [4];
  logic [3:0]  sat_m;
  logic [31:0] expq [$];

  always #5 clk = ~clk;

  pu_mux_bank #(.LANES(4), .DW(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .vrd_i(vrd_i), .sel_i(sel_i), .mode_i(mode_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .vrd_o(vrd_o), .sat_o(sat_o), .level_o(level_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model for one accepted transfer.
  // It applies the transfer to the model accumulators and queues the
  // expected result.
  task automatic model_xfer(input logic [31:0] d, input logic [7:0] s,
                            input logic [1:0] m);
    logic [31:0] res;
    logic [7:0]  r;
    int          sum;
    res = '0;
    for (int k = 0; k < 4; k++) begin
      r = d[int'(s[2*k +: 2])*8 +: 8];
      if (m == 2'd2) begin
        sum = int'(acc_m[k]) + int'(r);
        if (sum > 255) begin
          acc_m[k] = 8'hFF;
          sat_m[k] = 1'b1;
        end else begin
          acc_m[k] = sum[7:0];
        end
        res[k*8 +: 8] = acc_m[k];
      end else if (m == 2'd3) begin
        acc_m[k]      = r;
        sat_m[k]      = 1'b0;
        res[k*8 +: 8] = r;
      end else begin
        res[k*8 +: 8] = r;
      end
    end
    expq.push_back(res);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    vrd_i = '0; sel_i = 8'hE4; mode_i = 2'd0;
    for (int k = 0; k < 4; k++) acc_m[k] = '0;
    sat_m = '0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (level_o !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level_o); end
    checks++; if (sat_o !== 4'h0) begin errors++; $display("FAIL reset_sat got %h exp 0", sat_o); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (vrd_o !== 32'h0) begin errors++; $display("FAIL reset_vrd_o got %h exp 0", vrd_o); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_pass_and_crossbar(input logic [7:0] s, input logic [31:0] exp_out,
                                        input string name);
    out_ready = 1'b1;
    in_valid  = 1'b1; vrd_i = 32'h44332211; sel_i = s; mode_i = 2'd0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready got %b exp 1", name, in_ready); end
    model_xfer(vrd_i, sel_i, mode_i);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid got %b exp 0", name, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_out_valid got %b exp 1", name, out_valid); end
    checks++; if (vrd_o !== exp_out) begin errors++; $display("FAIL %s_data got %h exp %h", name, vrd_o, exp_out); end
    checks++; if (level_o !== 4'd1) begin errors++; $display("FAIL %s_level1 got %0d exp 1", name, level_o); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drained got %b exp 0", name, out_valid); end
    checks++; if (level_o !== 4'd0) begin errors++; $display("FAIL %s_level0 got %0d exp 0", name, level_o); end
    expq.delete();
  endtask

  task automatic test_accumulate();
    out_ready = 1'b0; sel_i = 8'hE4;
    in_valid = 1'b1; mode_i = 2'd3; vrd_i = 32'h000000F0;
    model_xfer(vrd_i, sel_i, mode_i); tick();
    mode_i = 2'd2; vrd_i = 32'h0000000A;
    model_xfer(vrd_i, sel_i, mode_i); tick();
    model_xfer(vrd_i, sel_i, mode_i); tick();
    in_valid = 1'b0;
    tick();
    checks++; if (level_o !== 4'd3) begin errors++; $display("FAIL acc_level got %0d exp 3", level_o); end
    checks++; if (sat_o !== 4'b0001) begin errors++; $display("FAIL acc_sat_set got %b exp 0001", sat_o); end
    checks++; if (vrd_o !== 32'h000000F0) begin errors++; $display("FAIL acc_r0 got %h exp 000000f0", vrd_o); end
    out_ready = 1'b1;
    tick();
    checks++; if (vrd_o !== 32'h000000FA) begin errors++; $display("FAIL acc_r1 got %h exp 000000fa", vrd_o); end
    tick();
    checks++; if (vrd_o !== 32'h000000FF) begin errors++; $display("FAIL acc_r2 got %h exp 000000ff", vrd_o); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL acc_drained got %b exp 0", out_valid); end
    in_valid = 1'b1; mode_i = 2'd3; vrd_i = 32'h00000005;
    model_xfer(vrd_i, sel_i, mode_i); tick();
    in_valid = 1'b0;
    tick();
    checks++; if (sat_o !== 4'b0000) begin errors++; $display("FAIL acc_sat_clear got %b exp 0000", sat_o); end
    checks++; if (vrd_o !== 32'h00000005) begin errors++; $display("FAIL acc_reload got %h exp 00000005", vrd_o); end
    tick();
    expq.delete();
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int pops = 0;
    int cyc  = 0;
    expq.delete();
    out_ready = 1'b0; mode_i = 2'd0; sel_i = 8'hE4;
    for (int c = 0; c < 15; c++) begin
      if (sent < 12) begin
        in_valid = 1'b1; vrd_i = 32'h10203040 + sent * 32'h01010101;
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        model_xfer(vrd_i, sel_i, mode_i);
        sent++;
      end
      tick();
    end
    checks++; if (sent !== 8) begin errors++; $display("FAIL bp_accepted got %0d exp 8", sent); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
    checks++; if (level_o !== 4'd8) begin errors++; $display("FAIL bp_level got %0d exp 8", level_o); end
    out_ready = 1'b1;
    while ((sent < 12 || expq.size() > 0) && cyc < 100) begin
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL bp_extra_output got %h exp none", vrd_o);
        end else if (vrd_o !== expq[0]) begin
          errors++; $display("FAIL bp_order got %h exp %h", vrd_o, expq[0]);
        end
        if (expq.size() > 0) void'(expq.pop_front());
        pops++;
      end
      if (sent < 12) begin
        in_valid = 1'b1; vrd_i = 32'h10203040 + sent * 32'h01010101;
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        model_xfer(vrd_i, sel_i, mode_i);
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (cyc >= 100) begin errors++; $display("FAIL bp_timeout got %0d cycles exp <100", cyc); end
    checks++; if (pops !== 12) begin errors++; $display("FAIL bp_pops got %0d exp 12", pops); end
    checks++; if (level_o !== 4'd0) begin errors++; $display("FAIL bp_final_level got %0d exp 0", level_o); end
  endtask

  task automatic test_random_pushpop();
    logic [31:0] d [20];
    logic [7:0]  s [20];
    logic [1:0]  m [20];
    int sent = 0;
    int pops = 0;
    int cyc  = 0;
    expq.delete();
    for (int i = 0; i < 20; i++) begin
      d[i] = $urandom;
      s[i] = 8'($urandom_range(0, 255));
      m[i] = 2'($urandom_range(0, 3));
    end
    while ((sent < 20 || expq.size() > 0) && cyc < 400) begin
      out_ready = (cyc < 10) ? 1'b0 : 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL rnd_extra_output got %h exp none", vrd_o);
        end else if (vrd_o !== expq[0]) begin
          errors++; $display("FAIL rnd_data got %h exp %h", vrd_o, expq[0]);
        end
        if (expq.size() > 0) void'(expq.pop_front());
        pops++;
      end
      if (sent < 20) begin
        in_valid = 1'b1; vrd_i = d[sent]; sel_i = s[sent]; mode_i = m[sent];
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        model_xfer(vrd_i, sel_i, mode_i);
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (cyc >= 400) begin errors++; $display("FAIL rnd_timeout got %0d cycles exp <400", cyc); end
    checks++; if (pops !== 20) begin errors++; $display("FAIL rnd_pops got %0d exp 20", pops); end
    checks++; if (sat_o !== sat_m) begin errors++; $display("FAIL rnd_sat got %b exp %b", sat_o, sat_m); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0; sel_i = 8'hE4;
    in_valid = 1'b1; mode_i = 2'd3; vrd_i = 32'hFFFFFFFF;
    tick();
    mode_i = 2'd2; vrd_i = 32'h01010101;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0;
    checks++; if (level_o !== 4'd5) begin errors++; $display("FAIL mid_level got %0d exp 5", level_o); end
    checks++; if (sat_o !== 4'hF) begin errors++; $display("FAIL mid_sat got %b exp 1111", sat_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) acc_m[k] = '0;
    sat_m = '0;
    expq.delete();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b exp 0", out_valid); end
    checks++; if (level_o !== 4'd0) begin errors++; $display("FAIL mid_level0 got %0d exp 0", level_o); end
    checks++; if (sat_o !== 4'h0) begin errors++; $display("FAIL mid_sat0 got %b exp 0000", sat_o); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b exp 1", in_ready); end
    // Accumulating onto a cleared bank must return the operands unchanged.
    in_valid = 1'b1; mode_i = 2'd2; vrd_i = 32'h04030201;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_entry got %b exp 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_acc_valid got %b exp 1", out_valid); end
    checks++; if (vrd_o !== 32'h04030201) begin errors++; $display("FAIL mid_acc_zero got %h exp 04030201", vrd_o); end
    out_ready = 1'b1;
    tick();
    checks++; if (level_o !== 4'd0) begin errors++; $display("FAIL mid_final_level got %0d exp 0", level_o); end
  endtask

  initial begin
    test_reset();
    test_pass_and_crossbar(8'hE4, 32'h44332211, "pass");
    test_pass_and_crossbar(8'h0D, 32'h11114422, "xbar");
    test_accumulate();
    test_backpressure();
    test_random_pushpop();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
